// File: rtl/sample_mul_pipe.sv
// Pipelined signed/unsigned multiplier with post-product shift, narrowing and overflow counting.
// Optional build macro SAMPLE_MUL_PIPE_SAT_EN: saturate dout on overflow instead of wrapping.
module sample_mul_pipe #(
    parameter int DIN0_WIDTH  = 8,
    parameter int DIN1_WIDTH  = 13,
    parameter int DOUT_WIDTH  = 13,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int SHIFT       = 0,
    parameter int NUM_STAGE   = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic [CNT_WIDTH-1:0]  ovf_cnt,
    input  logic                  cnt_clr
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int EW  = ((PW > DOUT_WIDTH) ? PW : DOUT_WIDTH) + 1;
    localparam int LST = NUM_STAGE - 1;
    localparam bit OUT_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic signed [EW-1:0] ONE  = 1;
    localparam logic signed [EW-1:0] OMAX = OUT_SIGNED ? ((ONE <<< (DOUT_WIDTH-1)) - ONE)
                                                       : ((ONE <<< DOUT_WIDTH) - ONE);
    localparam logic signed [EW-1:0] OMIN = OUT_SIGNED ? -(ONE <<< (DOUT_WIDTH-1))
                                                       : '0;

    logic                  a_msb;
    logic                  b_msb;
    logic signed [PW-1:0]  a_x;
    logic signed [PW-1:0]  b_x;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  res;
    logic signed [EW-1:0]  r_ext;
    logic                  ovf_c;
    logic [DOUT_WIDTH-1:0] dout_c;

    logic [NUM_STAGE-1:0]  vld_q;
    logic [NUM_STAGE-1:0]  ovf_q;
    logic [DOUT_WIDTH-1:0] dat_q [NUM_STAGE];
    logic                  stall;
    logic                  xfer_ovf;

    // Operands are widened straight to product width; the extra sign bits
    // are what the one-bit extension would have produced anyway.
    always_comb begin
        a_msb = (DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0;
        b_msb = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;
        a_x   = {{(PW-DIN0_WIDTH){a_msb}}, din0};
        b_x   = {{(PW-DIN1_WIDTH){b_msb}}, din1};
        prod  = a_x * b_x;
        res   = prod >>> SHIFT;
        r_ext = {{(EW-PW){res[PW-1]}}, res};
        ovf_c = (r_ext > OMAX) || (r_ext < OMIN);
    end

`ifdef SAMPLE_MUL_PIPE_SAT_EN
    always_comb begin
        dout_c = r_ext[DOUT_WIDTH-1:0];
        if (ovf_c) begin
            dout_c = r_ext[EW-1] ? OMIN[DOUT_WIDTH-1:0] : OMAX[DOUT_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        dout_c = r_ext[DOUT_WIDTH-1:0];
    end
`endif

    // Handshake: a beat moves on valid && ready at the rising edge. The whole
    // pipeline freezes while the last stage holds a result the consumer refuses,
    // so in_ready is simply the negation of that stall condition.
    assign stall     = vld_q[LST] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_q[LST];
    assign dout      = dat_q[LST];
    assign ovf       = ovf_q[LST];

    // Data registers load only with a valid beat so dout/ovf keep the last
    // result while bubbles pass through.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                dat_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= dout_c;
                ovf_q[0] <= ovf_c;
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                end
            end
        end
    end

    assign xfer_ovf = vld_q[LST] && out_ready && ovf_q[LST];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (xfer_ovf && (ovf_cnt != {CNT_WIDTH{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_mul_pipe.sv
// Directed bench for sample_mul_pipe: default, SHIFT=4 and CNT_WIDTH=2 instances.
// Expected values are hand computed; SAMPLE_MUL_PIPE_SAT_EN selects the saturating set.
module tb_sample_mul_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef SAMPLE_MUL_PIPE_SAT_EN
    localparam logic [12:0] E_M20000 = 13'h1000;
    localparam logic [12:0] E_P4096  = 13'h0FFF;
    localparam logic [12:0] E_SH_BIG = 13'h0FFF;
`else
    localparam logic [12:0] E_M20000 = 13'h11E0;
    localparam logic [12:0] E_P4096  = 13'h1000;
    localparam logic [12:0] E_SH_BIG = 13'h1EF0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- default instance ----------------
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_ovf, d_cnt_clr;
    logic [7:0]  d_din0;
    logic [12:0] d_din1, d_dout;
    logic [15:0] d_ovf_cnt;

    sample_mul_pipe u_def (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .din0(d_din0), .din1(d_din1),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .dout(d_dout), .ovf(d_ovf), .ovf_cnt(d_ovf_cnt), .cnt_clr(d_cnt_clr)
    );

    // ---------------- SHIFT=4 instance ----------------
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf, s_cnt_clr;
    logic [7:0]  s_din0;
    logic [12:0] s_din1, s_dout;
    logic [15:0] s_ovf_cnt;

    sample_mul_pipe #(.SHIFT(4)) u_sh (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din0(s_din0), .din1(s_din1),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .dout(s_dout), .ovf(s_ovf), .ovf_cnt(s_ovf_cnt), .cnt_clr(s_cnt_clr)
    );

    // ---------------- CNT_WIDTH=2 instance ----------------
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf, c_cnt_clr;
    logic [7:0]  c_din0;
    logic [12:0] c_din1, c_dout;
    logic [1:0]  c_ovf_cnt;

    sample_mul_pipe #(.CNT_WIDTH(2)) u_cw (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .din0(c_din0), .din1(c_din1),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .dout(c_dout), .ovf(c_ovf), .ovf_cnt(c_ovf_cnt), .cnt_clr(c_cnt_clr)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboards: {ovf, dout} ----------------
    logic [13:0] exp_q[$];
    logic [13:0] s_exp_q[$];

    always @(negedge clk) begin
        if (rst_n && d_out_valid && d_out_ready) begin
            if (exp_q.size() == 0) begin
                check("d_unexpected_out", 32'(d_out_valid), 32'd0);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                check("d_dout", 32'(d_dout), 32'(e[12:0]));
                check("d_ovf", 32'(d_ovf), 32'(e[13]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (s_exp_q.size() == 0) begin
                check("s_unexpected_out", 32'(s_out_valid), 32'd0);
            end else begin
                logic [13:0] e;
                e = s_exp_q.pop_front();
                check("s_dout", 32'(s_dout), 32'(e[12:0]));
                check("s_ovf", 32'(s_ovf), 32'(e[13]));
            end
        end
    end

    // ---------------- driver tasks (default instance) ----------------
    task automatic send(input logic [7:0] a, input logic [12:0] b,
                        input logic [12:0] ed, input logic eo);
        int n;
        @(posedge clk); #1;
        d_in_valid = 1'b1;
        d_din0     = a;
        d_din1     = b;
        n = 0;
        @(negedge clk);
        while (!d_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(d_in_ready), 32'd1);
        if (d_in_ready) exp_q.push_back({eo, ed});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        d_in_valid = 0; d_din0 = 0; d_din1 = 0; d_out_ready = 1; d_cnt_clr = 0;
        s_in_valid = 0; s_din0 = 0; s_din1 = 0; s_out_ready = 1; s_cnt_clr = 0;
        c_in_valid = 0; c_din0 = 0; c_din1 = 0; c_out_ready = 1; c_cnt_clr = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(d_out_valid), 32'd0);
        check("rst_ovf_cnt", 32'(d_ovf_cnt), 32'd0);
        check("rst_dout", 32'(d_dout), 32'd0);
        check("rst_in_ready", 32'(d_in_ready), 32'd1);
        rst_n = 1'b1;

        // Latency: 10 * -7 = -70, valid exactly two edges after acceptance
        send(8'd10, -13'sd7, 13'h1FBA, 1'b0);
        idle();
        @(negedge clk);
        check("lat_not_yet", 32'(d_out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(d_out_valid), 32'd1);
        drain("drain_lat");

        // 200 * -100 = -20000 overflows the 13-bit signed range
        send(8'd200, -13'sd100, E_M20000, 1'b1);
        idle();
        drain("drain_ovf");
        @(posedge clk); #1;
        check("ovf_cnt_1", 32'(d_ovf_cnt), 32'd1);

        // Range boundaries, back to back
        send(8'd1, 13'd4095, 13'h0FFF, 1'b0);
        send(8'd1, -13'sd4096, 13'h1000, 1'b0);
        send(8'd32, 13'd128, E_P4096, 1'b1);
        send(8'd7, -13'sd3, 13'h1FEB, 1'b0);
        idle();
        drain("drain_bound");
        @(posedge clk); #1;
        check("ovf_cnt_2", 32'(d_ovf_cnt), 32'd2);

        // Backpressure: consumer refuses for 5 cycles from the first result
        d_out_ready = 1'b0;
        fork
            begin
                send(8'd1, 13'd1, 13'd1, 1'b0);
                send(8'd2, 13'd2, 13'd4, 1'b0);
                send(8'd3, 13'd3, 13'd9, 1'b0);
                idle();
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!d_out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first_valid", 32'(d_out_valid), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_in_ready", 32'(d_in_ready), 32'd0);
                    check("bp_hold_dout", 32'(d_dout), 32'd1);
                end
                @(posedge clk); #1;
                d_out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        repeat (2) @(negedge clk);
        check("idle_out_valid", 32'(d_out_valid), 32'd0);
        check("idle_hold_dout", 32'(d_dout), 32'd9);

        // SHIFT=4 instance: large positive, -1 stays -1, floor of negative
        s_exp_q.push_back({1'b1, E_SH_BIG});
        s_exp_q.push_back({1'b0, 13'h1FFF});
        s_exp_q.push_back({1'b0, 13'h1FFE});
        @(posedge clk); #1;
        s_in_valid = 1'b1; s_din0 = 8'd255; s_din1 = 13'd4095;
        @(posedge clk); #1;
        s_din0 = 8'd1; s_din1 = -13'sd1;
        @(posedge clk); #1;
        s_din0 = 8'd1; s_din1 = -13'sd17;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (s_exp_q.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain_shift", 32'(s_exp_q.size()), 32'd0);

        // CNT_WIDTH=2: five overflows saturate at 3
        c_din0 = 8'd200; c_din1 = -13'sd100;
        @(posedge clk); #1;
        c_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("cnt_sat", 32'(c_ovf_cnt), 32'd3);

        // Clear on the same edge as an overflow transfer wins
        @(posedge clk); #1;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!c_out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("clr_ovf_seen", 32'(c_out_valid && c_ovf), 32'd1);
        c_cnt_clr = 1'b1;
        @(posedge clk); #1;
        c_cnt_clr = 1'b0;
        check("clr_wins", 32'(c_ovf_cnt), 32'd0);
        check("clr_transferred", 32'(c_out_valid), 32'd0);

        // Reset with two operations in flight
        send(8'd5, 13'd5, 13'd25, 1'b0);
        send(8'd6, 13'd6, 13'd36, 1'b0);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        check("pre_rst_valid", 32'(d_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(d_out_valid), 32'd0);
        check("async_rst_cnt", 32'(d_ovf_cnt), 32'd0);
        check("async_rst_ovf", 32'(d_ovf), 32'd0);
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(d_out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
